// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - screen/sprite sweep sequencer feeding ROM address and VGA pixel stages
// Optional DRAW_SEQ_CLEAR_EN adds a clear-draw input and a black-pixel flag.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        fullScreen,
  input  logic [7:0]  xOrigin,
  input  logic [6:0]  yOrigin,
  input  logic [4:0]  memorySelIn,
`ifdef DRAW_SEQ_CLEAR_EN
  input  logic        clear,
  output logic        black,
`endif
  output logic [14:0] screenAddr,
  output logic [10:0] spriteAddr,
  output logic [4:0]  memorySel,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_full;
  logic [7:0]  r_xo;
  logic [6:0]  r_yo;
  logic [4:0]  r_sel;
  logic [7:0]  r_col;
  logic [6:0]  r_row;
  logic [14:0] r_addr;

  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic        r_plot;

  logic [7:0]  w_last_col;
  logic [6:0]  w_last_row;
  logic        w_col_wrap;
  logic        w_last_pix;
  logic [8:0]  w_xsum;
  logic [7:0]  w_ysum;
  logic        w_clip;
  logic        w_drawing;
  logic        w_clear;
  logic        w_accept;

`ifdef DRAW_SEQ_CLEAR_EN
  logic        r_clear;
  logic        r_black;
  assign w_clear = r_clear;
  assign black   = r_black;
`else
  assign w_clear = 1'b0;
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last_col = r_full ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
  assign w_last_row = r_full ? 7'(SCREEN_H - 1) : 7'(SPRITE_W - 1);
  assign w_col_wrap = (r_col == w_last_col);
  assign w_last_pix = w_col_wrap && (r_row == w_last_row);

  // Origins are latched as zero for full-screen draws, so one adder serves both modes.
  assign w_xsum = {1'b0, r_xo} + {1'b0, r_col};
  assign w_ysum = {1'b0, r_yo} + {1'b0, r_row};
  assign w_clip = !r_full && ((w_xsum >= 9'(SCREEN_W)) || (w_ysum >= 8'(SCREEN_H)));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRAW;
      S_DRAW:  if (w_last_pix) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_drawing  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    screenAddr = 15'd0;
    spriteAddr = 11'd0;
    case (r_state)
      S_DRAW: begin
        w_drawing = 1'b1;
        busy      = 1'b1;
        if (!w_clear) begin
          if (r_full) screenAddr = r_addr;
          else        spriteAddr = r_addr[10:0];
        end
      end
      S_FLUSH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep counters; the linear address tracks row*W+col by plain increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_full <= 1'b0;
      r_xo   <= 8'd0;
      r_yo   <= 7'd0;
      r_sel  <= 5'd0;
      r_col  <= 8'd0;
      r_row  <= 7'd0;
      r_addr <= 15'd0;
    end else if (w_accept) begin
      r_full <= fullScreen;
      r_xo   <= fullScreen ? 8'd0 : xOrigin;
      r_yo   <= fullScreen ? 7'd0 : yOrigin;
      r_sel  <= memorySelIn;
      r_col  <= 8'd0;
      r_row  <= 7'd0;
      r_addr <= 15'd0;
    end else if (w_drawing) begin
      r_addr <= r_addr + 15'd1;
      if (w_col_wrap) begin
        r_col <= 8'd0;
        r_row <= r_row + 7'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

`ifdef DRAW_SEQ_CLEAR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clear <= 1'b0;
    end else if (w_accept) begin
      r_clear <= clear;
    end
  end
`endif

  // Pixel stage: one register behind the address, matching the ROM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x    <= 8'd0;
      r_y    <= 7'd0;
      r_plot <= 1'b0;
    end else if (w_drawing) begin
      r_x    <= w_xsum[7:0];
      r_y    <= w_ysum[6:0];
      r_plot <= !w_clip;
    end else begin
      r_x    <= 8'd0;
      r_y    <= 7'd0;
      r_plot <= 1'b0;
    end
  end

`ifdef DRAW_SEQ_CLEAR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_black <= 1'b0;
    end else begin
      r_black <= w_drawing && r_clear;
    end
  end
`endif

  assign memorySel = r_sel;
  assign x         = r_x;
  assign y         = r_y;
  assign plot      = r_plot;

endmodule
